coverfloat_txn_arbiter: RTL
===========================

# coverfloat_txn_arbiter

Round-robin arbiter that merges floating-point operation transactions from up to four independent sources (reference-model monitors, DUT monitors, vector replayers) onto the single coverage sampling channel. Each transaction carries the full coverfloat record: op, rm, a/b/c with their formats, result with its format, and exceptionBits. The coverage sampler sits downstream of a one-entry registered output stage with valid/ready backpressure. The block also counts delivered transactions.

## Interface
- `N_SRC`, default 2: number of requesters, legal range 2..4.
- `TXN_W`, default 640: packed transaction width; fixed at 640.
- Packed field layout, MSB to LSB:
  - op [639:608], rm [607:576]
  - a [575:448], b [447:320], c [319:192]
  - aFmt [191:184], bFmt [183:176], cFmt [175:168]
  - result [167:40], resultFmt [39:32], exceptionBits [31:0]
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: when low, no new grants are made. The output stage still drains.
- `req_valid` in N_SRC: per-source transaction present.
- `req_ready` out N_SRC: per-source accept. Combinational and one-hot or zero.
- `req_txn` in N_SRC*TXN_W: source i occupies bits [i*TXN_W +: TXN_W].
- `out_valid` out 1: output register holds a transaction.
- `out_ready` in 1: sampler accepts.
- `out_txn` out TXN_W: registered transaction.
- `out_src` out 2: index of the source that produced `out_txn`.
- `txn_count` out 32: number of completed output handshakes. Wraps modulo 2^32.

## Operation
- Output stage has two states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- `can_load` = en && (EMPTY || (FULL && out_ready)).
- Grant selection:
  - When `can_load` is high, grant the first source with req_valid=1.
  - Search order starts at `rr_ptr` and wraps to `rr_ptr-1` (modulo N_SRC).
  - `req_ready[g]`=1 only for the granted g. All other bits are 0.
  - When `can_load` is low, req_ready is all-zero.
- On a grant:
  - out_txn <= req_txn[g], out_src <= g, state goes to FULL.
  - rr_ptr <= (g+1) mod N_SRC.
- FULL && out_ready with no grant: state goes to EMPTY. out_txn and out_src hold their last values.
- FULL && !out_ready: out_txn and out_src hold. No grants are made.
- txn_count increments on every cycle with out_valid && out_ready.
- rr_ptr changes only on a grant.
- Source protocol:
  - The source must hold req_txn stable while req_valid && !req_ready.
  - The arbiter does not require req_valid to stay high; it grants only on the current valid.
- N_SRC < 4: out_src upper unused values never appear. Indices ≥ N_SRC are never granted.

## Timing
- Reset values:
  - out_valid=0, out_txn=0, out_src=0, txn_count=0
  - rr_ptr=0 (source 0 highest priority)
  - req_ready=0 during the reset cycle
- Latency: a request accepted in cycle t appears at out_valid/out_txn in cycle t+1.
- Throughput: with out_ready held high, one transaction per cycle is sustained. Load and drain happen in the same cycle.
- Fairness: under continuous requests from all sources, grants rotate 0,1,…,N_SRC-1. No source waits more than N_SRC-1 grants.
- Simultaneous requests: only one grant per cycle. Losers see req_ready=0 and retry next cycle.
- en falling while FULL: the held transaction is still delivered on out_ready. There are no further grants until en=1.
- reset mid-operation: the held transaction is discarded. Outputs return to reset values on the next edge, and the count clears.
- txn_count at 0xFFFF_FFFF plus a handshake gives 0.

## Test plan
- Reset with all req_valid=1: req_ready=0 in the reset cycle, out_valid=0, txn_count=0. The first grant after reset goes to source 0.
- N_SRC=2, both valid continuously, out_ready=1:
  - Grants alternate 0,1,0,1 with out_valid high every cycle from t+1.
  - out_src sequence is 0,1,0,1.
  - txn_count=4 after 4 handshakes.
- Backpressure: load source 1 with op=0x0000_0003 and a=0x3FF0…0. Hold out_ready=0 for 5 cycles.
  - out_txn stays stable and req_ready stays 0 for all 5 cycles.
  - The output is delivered on the first cycle with out_ready=1.
  - Source 0 is granted in that same cycle.
- Field integrity: drive a distinct value per field on source 0 (exceptionBits=0x1F, resultFmt=0x02, cFmt=0x01). Every field appears in out_txn at its documented bit position.
- en=0 while FULL: the held transaction drains on out_ready and out_valid falls. There are no grants for 3 cycles. After en=1, granting resumes at rr_ptr.
- Reset asserted while FULL with out_ready=0: out_valid=0 and txn_count=0 on the next cycle, and the held transaction is never delivered.

Source files
------------

// File: rtl/coverfloat_txn_arbiter_if.sv
// rtl/coverfloat_txn_arbiter_if.sv - request/output handshake bundle for the coverfloat transaction arbiter
interface coverfloat_txn_arbiter_if #(
    parameter int N_SRC = 2,
    parameter int TXN_W = 640
);
    logic [N_SRC-1:0]       req_valid;
    logic [N_SRC-1:0]       req_ready;
    logic [N_SRC*TXN_W-1:0] req_txn;
    logic                   out_valid;
    logic                   out_ready;
    logic [TXN_W-1:0]       out_txn;
    logic [1:0]             out_src;

    modport slave (
        input  req_valid, req_txn, out_ready,
        output req_ready, out_valid, out_txn, out_src
    );

    modport master (
        output req_valid, req_txn, out_ready,
        input  req_ready, out_valid, out_txn, out_src
    );
endinterface

// File: rtl/coverfloat_txn_arbiter.sv
// rtl/coverfloat_txn_arbiter.sv - round-robin merge of coverfloat transactions onto one registered output
module coverfloat_txn_arbiter #(
    parameter int N_SRC = 2,
    parameter int TXN_W = 640
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    coverfloat_txn_arbiter_if.slave bus,
    output logic [31:0]             txn_count
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [TXN_W-1:0] txn_q, txn_d;
    logic [1:0]       src_q, src_d;
    logic [1:0]       rr_q, rr_d;
    logic [31:0]      count_q, count_d;

    logic             can_load;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic [3:0]       valid_ext;
    logic [2:0]       cand;
    logic [2:0]       rr_inc;

    // Reset gates the grant path so no source sees ready during the reset cycle.
    assign can_load  = en && !reset && (state_q == ST_EMPTY || bus.out_ready);
    assign valid_ext = 4'(bus.req_valid);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        cand      = 3'd0;
        if (can_load) begin
            for (int k = 0; k < N_SRC; k++) begin
                cand = {1'b0, rr_q} + 3'(k);
                if (cand >= 3'(N_SRC)) begin
                    cand = cand - 3'(N_SRC);
                end
                if (!grant_vld && valid_ext[cand[1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[1:0];
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (grant_vld && grant_idx == 2'(k)) begin
                bus.req_ready[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        src_d   = src_q;
        rr_d    = rr_q;
        count_d = count_q;
        rr_inc  = {1'b0, grant_idx} + 3'd1;
        if (state_q == ST_FULL && bus.out_ready) begin
            count_d = count_q + 32'd1;
        end
        if (grant_vld) begin
            state_d = ST_FULL;
            src_d   = grant_idx;
            rr_d    = (rr_inc == 3'(N_SRC)) ? 2'd0 : rr_inc[1:0];
            for (int k = 0; k < N_SRC; k++) begin
                if (grant_idx == 2'(k)) begin
                    txn_d = bus.req_txn[k*TXN_W +: TXN_W];
                end
            end
        end else if (state_q == ST_FULL && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            txn_q   <= '0;
            src_q   <= 2'd0;
            rr_q    <= 2'd0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
            count_q <= count_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_txn   = txn_q;
    assign bus.out_src   = src_q;
    assign txn_count     = count_q;
endmodule
